par2ser: RTL and testbench



---
 rtl/par2ser_pkg.sv | 15 +
 rtl/par2ser_baudgen.sv | 41 ++++
 rtl/par2ser.sv | 143 ++++++++++++++
 tb/tb_par2ser.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/par2ser_pkg.sv
// Shared types and helpers for the par2ser serial transmitter.
// Contents: FSM state enum, counter width helper.
package par2ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Width of a counter spanning 0..n-1; never below one bit so n=1 still works.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/par2ser_baudgen.sv
// Bit-period divider for par2ser: one-cycle Tick every ClkDiv enabled cycles.
// Ports:
//   Clk, RstB  - clock, async active-low reset
//   Clear      - restart the period (counter to 0)
//   Enable     - count this cycle
//   Tick       - last cycle of the current bit period (decoded from the counter)
module par2ser_baudgen
  import par2ser_pkg::*;
#(
  parameter int unsigned ClkDiv = 1
) (
  input  logic Clk,
  input  logic RstB,
  input  logic Clear,
  input  logic Enable,
  output logic Tick
);

  localparam int unsigned CntW = cnt_w(ClkDiv);
  localparam logic [CntW-1:0] CntMax = CntW'(ClkDiv - 32'd1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign Tick = Enable && (cnt_q == CntMax);

  // Divider next state: clear wins, otherwise count and wrap on the tick.
  always_comb begin
    cnt_d = cnt_q;
    if (Clear) begin
      cnt_d = '0;
    end else if (Enable) begin
      cnt_d = Tick ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge Clk or negedge RstB) begin
    if (!RstB) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/par2ser.sv
// Parallel-to-serial transmitter: accepts a bitlen-bit word on a valid/ready
// handshake and shifts it out LSB first, one bit per ClkDiv cycles.
// Ports:
//   Clk, RstB      - clock, async active-low reset
//   ParDataIn      - word to send, captured on handshake
//   ParDataValid   - ParDataIn valid
//   ParDataReady   - combinational: a word can be accepted this cycle
//   SerDataOut     - serial data (shift register bit 0)
//   SerDataEn      - bit strobe, high on the last cycle of each bit period
//   Busy           - frame in progress
// Optional: define PAR2SER_HOLDBUF_EN for a one-entry holding register that
// accepts the next word during a frame and chains frames with no idle gap.
module par2ser
  import par2ser_pkg::*;
#(
  parameter int unsigned bitlen = 8,
  parameter int unsigned ClkDiv = 1
) (
  input  logic              Clk,
  input  logic              RstB,
  input  logic [bitlen-1:0] ParDataIn,
  input  logic              ParDataValid,
  output logic              ParDataReady,
  output logic              SerDataOut,
  output logic              SerDataEn,
  output logic              Busy
);

  localparam int unsigned BitW = cnt_w(bitlen);
  localparam logic [BitW-1:0] BitMax = BitW'(bitlen - 32'd1);

  state_e            state_q, state_d;
  logic [bitlen-1:0] shreg_q, shreg_d;
  logic [BitW-1:0]   bitcnt_q, bitcnt_d;
  logic              tick;
  logic              hs;
  logic              load;
  logic              frame_end;

`ifdef PAR2SER_HOLDBUF_EN
  logic [bitlen-1:0] hbuf_q, hbuf_d;
  logic              hfull_q, hfull_d;

  assign ParDataReady = !hfull_q;
`else
  assign ParDataReady = (state_q == IDLE);
`endif

  assign hs        = ParDataValid && ParDataReady;
  assign frame_end = tick && (bitcnt_q == BitMax);

  par2ser_baudgen #(
    .ClkDiv (ClkDiv)
  ) u_baudgen (
    .Clk    (Clk),
    .RstB   (RstB),
    .Clear  (load),
    .Enable (state_q == SHIFT),
    .Tick   (tick)
  );

  // Next-state: frame start, bit shifting and frame end (with optional chaining).
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    load     = 1'b0;
`ifdef PAR2SER_HOLDBUF_EN
    hbuf_d   = hbuf_q;
    hfull_d  = hfull_q;
`endif
    case (state_q)
      IDLE: begin
        if (hs) begin
          state_d  = SHIFT;
          shreg_d  = ParDataIn;
          bitcnt_d = '0;
          load     = 1'b1;
        end
      end
      SHIFT: begin
        if (tick) begin
          shreg_d  = shreg_q >> 1;
          bitcnt_d = bitcnt_q + BitW'(1);
        end
        if (frame_end) begin
          state_d  = IDLE;
          bitcnt_d = '0;
`ifdef PAR2SER_HOLDBUF_EN
          // Pending word (buffered, or arriving right now) starts at this edge.
          if (hfull_q) begin
            state_d = SHIFT;
            shreg_d = hbuf_q;
            hfull_d = 1'b0;
            load    = 1'b1;
          end else if (hs) begin
            state_d = SHIFT;
            shreg_d = ParDataIn;
            load    = 1'b1;
          end
`endif
        end
`ifdef PAR2SER_HOLDBUF_EN
        else if (hs) begin
          hbuf_d  = ParDataIn;
          hfull_d = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge RstB) begin
    if (!RstB) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
    end
  end

`ifdef PAR2SER_HOLDBUF_EN
  always_ff @(posedge Clk or negedge RstB) begin
    if (!RstB) begin
      hbuf_q  <= '0;
      hfull_q <= 1'b0;
    end else begin
      hbuf_q  <= hbuf_d;
      hfull_q <= hfull_d;
    end
  end
`endif

  // The shift register drains to zero, so bit 0 is 0 whenever idle.
  assign SerDataOut = shreg_q[0];
  assign SerDataEn  = tick;
  assign Busy       = (state_q == SHIFT);

endmodule

// File: tb/tb_par2ser.sv
// Self-checking bench for par2ser: one instance at ClkDiv=1 and one at ClkDiv=4,
// loopback receivers fed from a scoreboard queue plus directed cycle checks.
module tb_par2ser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic [7:0] a_din = '0;
  logic       a_valid = 1'b0;
  logic       a_ready, a_sout, a_sen, a_busy;

  logic [7:0] b_din = '0;
  logic       b_valid = 1'b0;
  logic       b_ready, b_sout, b_sen, b_busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  int a_pushes = 0, a_words = 0, a_bits = 0;
  int b_pushes = 0, b_words = 0, b_bits = 0;
  logic [7:0] a_rx = '0, b_rx = '0;

  always #5 clk = ~clk;

  par2ser #(.bitlen(8), .ClkDiv(1)) dut (
    .Clk(clk), .RstB(rst_n), .ParDataIn(a_din), .ParDataValid(a_valid),
    .ParDataReady(a_ready), .SerDataOut(a_sout), .SerDataEn(a_sen), .Busy(a_busy)
  );

  par2ser #(.bitlen(8), .ClkDiv(4)) dut4 (
    .Clk(clk), .RstB(rst_n), .ParDataIn(b_din), .ParDataValid(b_valid),
    .ParDataReady(b_ready), .SerDataOut(b_sout), .SerDataEn(b_sen), .Busy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Loopback receivers: shift in on SerDataEn, MSB-side insertion.
  always @(negedge clk) begin
    logic [7:0] exp_w;
    if (!rst_n) begin
      a_bits = 0;
    end else if (a_sen) begin
      a_rx = {a_sout, a_rx[7:1]};
      a_bits++;
      if (a_bits == 8) begin
        a_bits = 0;
        a_words++;
        exp_w = (q_a.size() != 0) ? q_a.pop_front() : 8'hxx;
        chk("a_loopback", 32'(a_rx), 32'(exp_w));
      end
    end
  end

  always @(negedge clk) begin
    logic [7:0] exp_w;
    if (!rst_n) begin
      b_bits = 0;
    end else if (b_sen) begin
      b_rx = {b_sout, b_rx[7:1]};
      b_bits++;
      if (b_bits == 8) begin
        b_bits = 0;
        b_words++;
        exp_w = (q_b.size() != 0) ? q_b.pop_front() : 8'hxx;
        chk("b_loopback", 32'(b_rx), 32'(exp_w));
      end
    end
  end

  // Present a word, wait (bounded) for ready, handshake; returns 1 time unit
  // after the handshake edge with valid still high.
  task automatic start_a(input logic [7:0] d);
    int w;
    w = 0;
    @(negedge clk);
    a_din   = d;
    a_valid = 1'b1;
    while (!a_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("a_ready_wait", 32'(a_ready), 32'd1);
    q_a.push_back(d);
    a_pushes++;
    @(posedge clk);
    #1;
  endtask

  // Single word at ClkDiv=1 with cycle-exact checks.
  task automatic send_a_full(input logic [7:0] d);
    start_a(d);
    a_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("single_en", 32'(a_sen), 32'd1);
      chk("single_out", 32'(a_sout), 32'(d[k-1]));
      chk("single_busy", 32'(a_busy), 32'd1);
    end
    @(negedge clk);
    chk("single_end_busy", 32'(a_busy), 32'd0);
    chk("single_end_ready", 32'(a_ready), 32'd1);
    chk("single_end_en", 32'(a_sen), 32'd0);
  endtask

  // Valid held high across two words; checks gap/chaining and single capture.
  task automatic b2b(input logic [7:0] d1, input logic [7:0] d2);
    int   hs_cnt;
    bit   drop;
    logic exp_en, exp_out;
    hs_cnt = 0;
    drop   = 1'b0;
    start_a(d1);
    a_din = d2;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (drop) begin
        a_valid = 1'b0;
        drop    = 1'b0;
      end
`ifdef PAR2SER_HOLDBUF_EN
      exp_en  = (k <= 16);
      exp_out = (k <= 8) ? d1[k-1] : (k <= 16) ? d2[k-9] : 1'b0;
`else
      exp_en  = (k <= 8) || (k >= 10 && k <= 17);
      exp_out = (k <= 8) ? d1[k-1] : (k >= 10 && k <= 17) ? d2[k-10] : 1'b0;
`endif
      chk("b2b_en", 32'(a_sen), 32'(exp_en));
      chk("b2b_out", 32'(a_sout), 32'(exp_out));
      chk("b2b_busy", 32'(a_busy), 32'(exp_en));
      if (a_valid && a_ready) begin
        q_a.push_back(d2);
        a_pushes++;
        hs_cnt++;
        drop = 1'b1;
      end
    end
    a_valid = 1'b0;
    chk("b2b_second_hs", 32'(hs_cnt), 32'd1);
  endtask

  initial begin
    int w;

    // Reset
    repeat (3) @(negedge clk);
    chk("rst_a_out", 32'(a_sout), 32'd0);
    chk("rst_a_en", 32'(a_sen), 32'd0);
    chk("rst_a_busy", 32'(a_busy), 32'd0);
    chk("rst_a_ready", 32'(a_ready), 32'd1);
    chk("rst_b_out", 32'(b_sout), 32'd0);
    chk("rst_b_en", 32'(b_sen), 32'd0);
    chk("rst_b_busy", 32'(b_busy), 32'd0);
    chk("rst_b_ready", 32'(b_ready), 32'd1);
    rst_n = 1'b1;

    // Single word, ClkDiv=1
    send_a_full(8'hA5);

    // Divided rate, ClkDiv=4
    @(negedge clk);
    b_din   = 8'h3C;
    b_valid = 1'b1;
    w = 0;
    while (!b_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("b_ready_wait", 32'(b_ready), 32'd1);
    q_b.push_back(8'h3C);
    b_pushes++;
    @(posedge clk);
    #1;
    b_valid = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      chk("div_en", 32'(b_sen), 32'((k % 4) == 0));
      chk("div_out", 32'(b_sout), 32'(b_din[(k-1)/4]));
      chk("div_busy", 32'(b_busy), 32'd1);
    end
    @(negedge clk);
    chk("div_end_busy", 32'(b_busy), 32'd0);
    chk("div_end_ready", 32'(b_ready), 32'd1);

    // Back-to-back with valid held
    b2b(8'h01, 8'hFF);
    repeat (2) @(negedge clk);

    // Reset mid-frame after three bits
    start_a(8'hF0);
    a_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy_before", 32'(a_busy), 32'd1);
    chk("mid_en_before", 32'(a_sen), 32'd1);
    #1;
    rst_n = 1'b0;
    void'(q_a.pop_back());
    a_pushes--;
    #1;
    chk("mid_rst_out", 32'(a_sout), 32'd0);
    chk("mid_rst_en", 32'(a_sen), 32'd0);
    chk("mid_rst_busy", 32'(a_busy), 32'd0);
    chk("mid_rst_ready", 32'(a_ready), 32'd1);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    send_a_full(8'h5A);

    // Valid without ready: waiting word must go out exactly once
    b2b(8'h11, 8'h96);

    repeat (12) @(negedge clk);
    chk("a_queue_empty", 32'(q_a.size()), 32'd0);
    chk("b_queue_empty", 32'(q_b.size()), 32'd0);
    chk("a_word_count", 32'(a_words), 32'(a_pushes));
    chk("b_word_count", 32'(b_words), 32'(b_pushes));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
